// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
//
// Owns the architectural fetch PC, presents it as the instruction-memory
// read address, and latches the fetched word into IF/ID. Per-edge priority
// is reset, then flush (redirect), then stall (hold), then advance (pc+4).
// Fetches outside the text window are replaced by bubbles, but the PC still
// advances so the pipeline can drain past the end of the program.
//
// Ports:
//   clk, rstn      single clock, synchronous active-low reset
//   imem_addr      read address to instruction memory (== pc)
//   imem_rdata     combinational instruction word at imem_addr
//   stall          hold pc and IF/ID this cycle
//   flush          squash IF/ID and load redirect_pc (word aligned)
//   redirect_pc    new fetch address, used only with flush
//   pc             current fetch PC
//   if_id_pc       PC of the instruction held in IF/ID
//   if_id_instr    instruction held in IF/ID (NOP_INSTR when empty)
//   if_id_valid    IF/ID holds a real instruction
//   oob            pc lies outside [TEXT_START, TEXT_START+TEXT_BYTES)
//   cnt_cycles     saturating count of non-reset cycles
//   cnt_stalls     saturating count of effective stall cycles
//   cnt_flushes    saturating count of flush cycles
module fetch_stage #(
  parameter logic [31:0] TEXT_START = 32'h00400000,
  parameter int unsigned TEXT_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        oob,
  output logic [31:0] cnt_cycles,
  output logic [31:0] cnt_stalls,
  output logic [31:0] cnt_flushes
);

  // Window bounds carried in 33 bits so the upper bound cannot overflow.
  localparam logic [32:0] TEXT_LO = {1'b0, TEXT_START};
  localparam logic [32:0] TEXT_HI = {1'b0, TEXT_START} + 33'(TEXT_BYTES);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0;
  logic [31:0] if_id_pc_p1, if_id_instr_p1;
  logic        vld_p1;
  logic [31:0] cnt_cycles_q, cnt_stalls_q, cnt_flushes_q;
  logic [31:0] cnt_cycles_d, cnt_stalls_d, cnt_flushes_d;
  logic        stall_eff, advance, oob_p0;

  assign stall_eff = stall && !flush;
  assign advance   = !stall && !flush;
  assign oob_p0    = ({1'b0, pc_p0} < TEXT_LO) || ({1'b0, pc_p0} >= TEXT_HI);

  assign cnt_cycles_d  = sat_inc(cnt_cycles_q);
  assign cnt_stalls_d  = stall_eff ? sat_inc(cnt_stalls_q) : cnt_stalls_q;
  assign cnt_flushes_d = flush ? sat_inc(cnt_flushes_q) : cnt_flushes_q;

  // FSM: tracks whether the stage is currently held by a stall.
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)          state_d = RUN;
    else if (stall_eff) state_d = HOLD;
    else                state_d = RUN;
  end

  // Stage 0: fetch PC register.
  always_ff @(posedge clk) begin
    if (!rstn)        pc_p0 <= TEXT_START;
    else if (flush)   pc_p0 <= redirect_pc & 32'hFFFF_FFFC;
    else if (advance) pc_p0 <= pc_p0 + 32'd4;
  end

  // Stage 1: IF/ID register. Out-of-window fetches become bubbles but keep
  // their PC so downstream can still see where fetch has got to.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      if_id_pc_p1    <= 32'd0;
      if_id_instr_p1 <= NOP_INSTR;
      vld_p1         <= 1'b0;
    end else if (advance) begin
      if_id_pc_p1    <= pc_p0;
      if_id_instr_p1 <= oob_p0 ? NOP_INSTR : imem_rdata;
      vld_p1         <= !oob_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_cycles_q  <= 32'd0;
      cnt_stalls_q  <= 32'd0;
      cnt_flushes_q <= 32'd0;
    end else begin
      cnt_cycles_q  <= cnt_cycles_d;
      cnt_stalls_q  <= cnt_stalls_d;
      cnt_flushes_q <= cnt_flushes_d;
    end
  end

  assign imem_addr   = pc_p0;
  assign pc          = pc_p0;
  assign oob         = oob_p0;
  assign if_id_pc    = if_id_pc_p1;
  assign if_id_instr = if_id_instr_p1;
  assign if_id_valid = vld_p1;
  assign cnt_cycles  = cnt_cycles_q;
  assign cnt_stalls  = cnt_stalls_q;
  assign cnt_flushes = cnt_flushes_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] TS   = 32'h00400000;
  localparam int          TB   = 1024;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam longint      MAXC = 64'h00000000FFFFFFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_rdata, pc, if_id_pc, if_id_instr;
  logic        if_id_valid, oob;
  logic [31:0] cnt_cycles, cnt_stalls, cnt_flushes;

  int n_cmp = 0, n_bad = 0;

  logic [31:0] mem [256];

  // Reference state
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_valid;
  longint      m_cyc, m_stl, m_fl;

  fetch_stage #(.TEXT_START(TS), .TEXT_BYTES(TB), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .pc(pc),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .oob(oob), .cnt_cycles(cnt_cycles), .cnt_stalls(cnt_stalls),
    .cnt_flushes(cnt_flushes)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read, garbage outside the window.
  always_comb begin
    logic [31:0] off;
    off = imem_addr - TS;
    if (imem_addr >= TS && off < 32'(TB)) imem_rdata = mem[off[9:2]];
    else                                  imem_rdata = 32'hBAD0BAD0;
  end

  function automatic longint clip(input longint v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic in_text(input logic [31:0] a);
    return (longint'(a) >= longint'(TS)) && (longint'(a) < longint'(TS) + TB);
  endfunction

  // Architectural effect of one posedge, from the priority rules.
  task automatic model_edge(input logic r, input logic s, input logic f,
                            input logic [31:0] rp);
    if (!r) begin
      m_pc = TS; m_ifpc = 0; m_instr = NOP; m_valid = 0;
      m_cyc = 0; m_stl = 0; m_fl = 0;
    end else begin
      m_cyc = clip(m_cyc + 1);
      if (f) begin
        m_pc = (rp / 4) * 4;
        m_ifpc = 0; m_instr = NOP; m_valid = 0;
        m_fl = clip(m_fl + 1);
      end else if (s) begin
        m_stl = clip(m_stl + 1);
      end else begin
        if (in_text(m_pc)) begin
          m_instr = mem[int'((m_pc - TS) / 4)];
          m_valid = 1;
        end else begin
          m_instr = NOP;
          m_valid = 0;
        end
        m_ifpc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic [31:0] rp);
    @(negedge clk);
    rstn = r; stall = s; flush = f; redirect_pc = rp;
    @(posedge clk);
    model_edge(r, s, f, rp);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0);
    n_cmp++;
    if ({pc, if_id_pc, if_id_instr, if_id_valid} !== {TS, 32'd0, NOP, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got pc=%h ifpc=%h instr=%h v=%b, want pc=%h ifpc=0 instr=%h v=0",
               pc, if_id_pc, if_id_instr, if_id_valid, TS, NOP);
    end
    n_cmp++;
    if ({cnt_cycles, cnt_stalls, cnt_flushes} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_counters: got %h %h %h, want all 0", cnt_cycles, cnt_stalls, cnt_flushes);
    end
    n_cmp++;
    if ({imem_addr, oob} !== {TS, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_addr: got addr=%h oob=%b, want %h 0", imem_addr, oob, TS);
    end
  endtask

  task automatic test_free_run;
    mem[0] = 32'h00500093; mem[1] = 32'h00A00113; mem[2] = 32'h002081B3;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    n_cmp++;
    if ({pc, if_id_pc, if_id_instr, if_id_valid} !== {32'h0040000C, 32'h00400008, 32'h002081B3, 1'b1}) begin
      n_bad++;
      $display("FAIL free_run: got pc=%h ifpc=%h instr=%h v=%b, want 0040000c 00400008 002081b3 1",
               pc, if_id_pc, if_id_instr, if_id_valid);
    end
    n_cmp++;
    if (cnt_cycles !== 32'd3) begin
      n_bad++;
      $display("FAIL free_run_cycles: got %0d, want 3", cnt_cycles);
    end
  endtask

  task automatic test_stall;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 0);
      n_cmp++;
      if ({pc, if_id_pc, if_id_instr, if_id_valid} !== {32'h00400008, 32'h00400004, mem[1], 1'b1}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h ifpc=%h instr=%h v=%b, want 00400008 00400004 %h 1",
                 i, pc, if_id_pc, if_id_instr, if_id_valid, mem[1]);
      end
    end
    n_cmp++;
    if (cnt_stalls !== 32'd2) begin
      n_bad++;
      $display("FAIL stall_count: got %0d, want 2", cnt_stalls);
    end
    cyc(1, 0, 0, 0);
    n_cmp++;
    if ({pc, if_id_pc, if_id_instr} !== {32'h0040000C, 32'h00400008, mem[2]}) begin
      n_bad++;
      $display("FAIL stall_release: got pc=%h ifpc=%h instr=%h, want 0040000c 00400008 %h",
               pc, if_id_pc, if_id_instr, mem[2]);
    end
  endtask

  task automatic test_flush_beats_stall;
    logic [31:0] stl_before;
    stl_before = cnt_stalls;
    cyc(1, 1, 1, 32'h00400022);
    n_cmp++;
    if ({pc, if_id_pc, if_id_instr, if_id_valid} !== {32'h00400020, 32'd0, NOP, 1'b0}) begin
      n_bad++;
      $display("FAIL flush_state: got pc=%h ifpc=%h instr=%h v=%b, want 00400020 0 %h 0",
               pc, if_id_pc, if_id_instr, if_id_valid, NOP);
    end
    n_cmp++;
    if ({cnt_flushes, cnt_stalls} !== {32'd1, stl_before}) begin
      n_bad++;
      $display("FAIL flush_counts: got fl=%0d stl=%0d, want fl=1 stl=%0d", cnt_flushes, cnt_stalls, stl_before);
    end
    cyc(1, 0, 0, 0);
    n_cmp++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {32'h00400020, mem[8], 1'b1}) begin
      n_bad++;
      $display("FAIL flush_redirect_fetch: got ifpc=%h instr=%h v=%b, want 00400020 %h 1",
               if_id_pc, if_id_instr, if_id_valid, mem[8]);
    end
  endtask

  task automatic test_oob_drain;
    cyc(1, 0, 1, 32'h004003FC);
    n_cmp++;
    if ({pc, oob} !== {32'h004003FC, 1'b0}) begin
      n_bad++;
      $display("FAIL oob_last_word: got pc=%h oob=%b, want 004003fc 0", pc, oob);
    end
    cyc(1, 0, 0, 0);
    n_cmp++;
    if ({pc, oob, if_id_instr, if_id_valid} !== {32'h00400400, 1'b1, mem[255], 1'b1}) begin
      n_bad++;
      $display("FAIL oob_edge: got pc=%h oob=%b instr=%h v=%b, want 00400400 1 %h 1",
               pc, oob, if_id_instr, if_id_valid, mem[255]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      n_cmp++;
      if ({if_id_valid, if_id_instr, if_id_pc, oob} !== {1'b0, NOP, m_ifpc, 1'b1}) begin
        n_bad++;
        $display("FAIL oob_drain[%0d]: got v=%b instr=%h ifpc=%h oob=%b, want 0 %h %h 1",
                 i, if_id_valid, if_id_instr, if_id_pc, oob, NOP, m_ifpc);
      end
    end
    n_cmp++;
    if ({pc, if_id_pc} !== {32'h00400410, 32'h0040040C}) begin
      n_bad++;
      $display("FAIL oob_drain_pc: got pc=%h ifpc=%h, want 00400410 0040040c", pc, if_id_pc);
    end
  endtask

  task automatic test_wrap_sat;
    cyc(1, 0, 1, 32'hFFFFFFFF);
    n_cmp++;
    if ({pc, oob} !== {32'hFFFFFFFC, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_redirect: got pc=%h oob=%b, want fffffffc 1", pc, oob);
    end
    cyc(1, 0, 0, 0);
    n_cmp++;
    if ({pc, oob, if_id_pc, if_id_valid} !== {32'h00000000, 1'b1, 32'hFFFFFFFC, 1'b0}) begin
      n_bad++;
      $display("FAIL wrap_advance: got pc=%h oob=%b ifpc=%h v=%b, want 0 1 fffffffc 0",
               pc, oob, if_id_pc, if_id_valid);
    end
    force dut.cnt_cycles_d = 32'hFFFFFFFF;
    cyc(1, 0, 0, 0);
    release dut.cnt_cycles_d;
    m_cyc = MAXC;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0);
      n_cmp++;
      if (cnt_cycles !== 32'hFFFFFFFF) begin
        n_bad++;
        $display("FAIL cycles_saturate[%0d]: got %h, want ffffffff", i, cnt_cycles);
      end
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h12345678);
    n_cmp++;
    if ({pc, if_id_valid, cnt_cycles, cnt_stalls, cnt_flushes} !== {TS, 1'b0, 96'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: got pc=%h v=%b cnt=%h/%h/%h, want %h 0 0/0/0",
               pc, if_id_valid, cnt_cycles, cnt_stalls, cnt_flushes, TS);
    end
  endtask

  task automatic test_random;
    logic        r, s, f;
    logic [31:0] rp;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       rp = $urandom;
        1:       rp = TS + 32'(TB) - 32'($urandom_range(0, 12));
        default: rp = TS + 32'($urandom_range(0, TB - 1));
      endcase
      cyc(r, s, f, rp);
      n_cmp++;
      if ({pc, imem_addr, oob, if_id_pc, if_id_instr, if_id_valid} !==
          {m_pc, m_pc, !in_text(m_pc), m_ifpc, m_instr, m_valid}) begin
        n_bad++;
        $display("FAIL random_state[%0d]: got pc=%h oob=%b ifpc=%h instr=%h v=%b, want %h %b %h %h %b",
                 i, pc, oob, if_id_pc, if_id_instr, if_id_valid,
                 m_pc, !in_text(m_pc), m_ifpc, m_instr, m_valid);
      end
      n_cmp++;
      if ({cnt_cycles, cnt_stalls, cnt_flushes} !== {m_cyc[31:0], m_stl[31:0], m_fl[31:0]}) begin
        n_bad++;
        $display("FAIL random_counters[%0d]: got %0d/%0d/%0d, want %0d/%0d/%0d",
                 i, cnt_cycles, cnt_stalls, cnt_flushes, m_cyc, m_stl, m_fl);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    m_pc = TS; m_ifpc = 0; m_instr = NOP; m_valid = 0;
    m_cyc = 0; m_stl = 0; m_fl = 0;
    test_reset;
    test_free_run;
    test_stall;
    test_flush_beats_stall;
    test_oob_drain;
    test_wrap_sat;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined core. It owns the architectural `pc`, drives the instruction-memory read address, and latches the fetched word into IF/ID for decode. It honours stall requests from the hazard unit and flush/redirect requests from branch resolution in EX. It also keeps saturating performance counters that the bench reads hierarchically.

## Interface
- `TEXT_START`, default `'h00400000`: reset PC and base of instruction memory.
- `TEXT_BYTES`, default `1024`: size of instruction memory in bytes.
- `NOP_INSTR`, default `32'h00000013`: bubble encoding (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on posedge.
- `rstn` in 1: reset, synchronous, active-low.
- `imem_addr` out 32: instruction-memory read address; combinationally equal to `pc`.
- `imem_rdata` in 32: instruction word at `imem_addr`; combinational read, valid in the same cycle.
- `stall` in 1: hold PC and IF/ID this cycle (load-use hazard).
- `flush` in 1: squash IF/ID and redirect the PC.
- `redirect_pc` in 32: new PC; sampled only when `flush=1`.
- `pc` out 32: current fetch PC, registered.
- `if_id_pc` out 32: PC of the instruction held in IF/ID.
- `if_id_instr` out 32: instruction held in IF/ID.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `oob` out 1: combinational; `pc` is outside `[TEXT_START, TEXT_START+TEXT_BYTES)`.
- `cnt_cycles` out 32: cycles since reset.
- `cnt_stalls` out 32: cycles with an effective stall.
- `cnt_flushes` out 32: cycles with `flush=1`.

## Operation
- Per-cycle action priority, evaluated at posedge: `rstn=0` first, then `flush`, then `stall`, then advance.
- **Reset** (`rstn=0` at posedge) sets:
  - `pc=TEXT_START`, `if_id_pc=0`, `if_id_instr=NOP_INSTR`, `if_id_valid=0`;
  - all counters to 0;
  - FSM to `RUN`.
- **Flush** (`flush=1`, with or without `stall`):
  - `pc <= {redirect_pc[31:2],2'b00}`; the low two bits are forced to zero.
  - IF/ID becomes `NOP_INSTR`, `valid=0`, `if_id_pc=0`.
  - `cnt_flushes++`.
  - FSM returns to `RUN`.
- **Stall** (`stall=1`, `flush=0`):
  - `pc` and all IF/ID outputs hold.
  - `cnt_stalls++`.
  - FSM enters or stays in `HOLD`.
- **Advance** (neither asserted):
  - `pc <= pc+4`, modulo 2^32; `0xFFFFFFFC` wraps to `0`.
  - If `oob=0`: `if_id_instr <= imem_rdata`, `if_id_pc <= pc`, `if_id_valid <= 1`.
  - If `oob=1`: IF/ID gets `NOP_INSTR`, `valid=0`, `if_id_pc <= pc`, and PC still advances. This lets the pipeline drain past the last instruction, since the bench exits at `end_of_text+16`.
  - FSM goes to `RUN`.
- **FSM**:
  - `RUN` → `HOLD` on an effective stall.
  - `HOLD` → `RUN` on advance or flush.
  - State is observable only through counters and assertions. The FSM has no effect on datapath outputs beyond the rules above.
- **Counters**:
  - `cnt_cycles` increments every non-reset cycle.
  - All counters saturate at `32'hFFFFFFFF` and do not wrap.
- **Bounds**: `oob` is computed with unsigned compare on the full 32 bits. `TEXT_START+TEXT_BYTES` is evaluated in 33 bits so there is no overflow.

## Timing
- `imem_addr`/`oob` follow `pc` with zero latency.
- Fetch-to-IF/ID latency is 1 cycle: an instruction fetched at PC=A appears on `if_id_*` after the next posedge.
- A flush at posedge N means the first redirected instruction is in IF/ID after posedge N+1. The squash penalty is 1 bubble from this stage; squashing ID/EX is decode's job.
- A stall held for k cycles delays `pc` by exactly k cycles, and IF/ID is unchanged throughout.
- `rstn` asserted mid-stall or mid-flush overrides both on that edge. The first fetch (address `TEXT_START`) is latched at the first posedge with `rstn=1`.
- No output is driven from the negedge; negedge register-file writes are outside this block.

## Test plan
- **Reset then free-run**: `rstn=0` for 1 edge, then 3 cycles with imem returning `0x00500093`, `0x00A00113`, `0x002081B3` → `pc=0x0040000C`; IF/ID holds `0x002081B3`, `if_id_pc=0x00400008`, `valid=1`; `cnt_cycles=3`.
- **Stall**: at `pc=0x00400008`, hold `stall=1` for 2 cycles → `pc` and IF/ID unchanged; `cnt_stalls=2`. On release, `pc=0x0040000C` after 1 edge.
- **Flush beats stall**: `flush=1`, `stall=1`, `redirect_pc=0x00400022` → `pc=0x00400020`; IF/ID is `NOP_INSTR` with `valid=0`; `cnt_flushes=1`; `cnt_stalls` unchanged.
- **Out of bounds / drain**: advance from `pc=0x004003FC` → `oob=0` at `0x004003FC`, then `oob=1`. IF/ID valid stays 0 from `pc=0x00400400` onward while `pc` reaches `0x00400410` after 4 more edges.
- **Wrap and saturation**: redirect to `0xFFFFFFFC` then advance → `pc=0x00000000`, `oob=1`. Force `cnt_cycles` to `0xFFFFFFFF` → it stays `0xFFFFFFFF`.
- **Reset mid-operation**: `rstn=0` together with `flush=1` → `pc=0x00400000`, all counters 0, `valid=0`.
